z_result_stage: RTL and testbench

//  Result-capture stage directly downstream of the shifter (SHR) and other ALU units.

---
 rtl/z_result_stage_pkg.sv | 26 ++
 rtl/z_result_stage_if.sv | 34 +++
 rtl/z_result_fifo.sv | 62 ++++++
 rtl/z_result_stage.sv | 53 +++++
 tb/tb_z_result_stage.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/z_result_stage_pkg.sv
// rtl/z_result_stage_pkg.sv - op codes and width rule shared by the result stage
// Wide (MUL/DIV) results carry a meaningful upper half; every other op is lo-only.
package z_result_stage_pkg;

  localparam int OPW   = 5;
  localparam int WIDTH = 32;

  typedef enum logic [OPW-1:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_SHR  = 5'd4,
    OP_SHRA = 5'd5,
    OP_SHL  = 5'd6,
    OP_ROR  = 5'd7,
    OP_ROL  = 5'd8,
    OP_MUL  = 5'd9,
    OP_DIV  = 5'd10
  } op_e;

  function automatic logic is_wide(input logic [OPW-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/z_result_stage_if.sv
// rtl/z_result_stage_if.sv - upstream result and downstream head handshakes
// master = the ALU/bus side driving results and consuming the head; slave = the stage.
interface z_result_stage_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int OPW   = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   in_op;
  logic [WIDTH-1:0] in_hi;
  logic [WIDTH-1:0] in_lo;
  logic             out_valid;
  logic             out_ready;
  logic [OPW-1:0]   z_op;
  logic [WIDTH-1:0] z_hi;
  logic [WIDTH-1:0] z_lo;
  logic             flag_zero;
  logic             flag_neg;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_op, in_hi, in_lo, out_ready,
    input  in_ready, out_valid, z_op, z_hi, z_lo, flag_zero, flag_neg, count
  );

  modport slave (
    input  in_valid, in_op, in_hi, in_lo, out_ready,
    output in_ready, out_valid, z_op, z_hi, z_lo, flag_zero, flag_neg, count
  );

endinterface

// File: rtl/z_result_fifo.sv
// rtl/z_result_fifo.sv - generic DEPTH-entry synchronous FIFO with flush
// Read data is forced to zero while empty so no stale entry ever leaks out.
module z_result_fifo #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // full refuses a push even when a pop frees a slot in the same cycle
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/z_result_stage.sv
// rtl/z_result_stage.sv - registers ALU/shifter Z results into an in-order buffer
// Applies the hi-half width rule and computes flags once, at push time.
module z_result_stage
  import z_result_stage_pkg::*;
#(
  parameter int WIDTH = z_result_stage_pkg::WIDTH,
  parameter int DEPTH = 2,
  parameter int OPW   = z_result_stage_pkg::OPW
) (
  input  logic clk,
  input  logic clr_n,
  input  logic flush,
  z_result_stage_if.slave bus
);

  localparam int DW = OPW + 2 + 2 * WIDTH;

  logic             wide;
  logic [WIDTH-1:0] hi_store;
  logic             zero_in;
  logic             neg_in;
  logic [DW-1:0]    wdata;
  logic [DW-1:0]    rdata;
  logic             full;
  logic             empty;

  assign wide     = is_wide(5'(bus.in_op));
  assign hi_store = wide ? bus.in_hi : '0;
  assign zero_in  = wide ? ({bus.in_hi, bus.in_lo} == '0) : (bus.in_lo == '0);
  assign neg_in   = wide ? bus.in_hi[WIDTH-1] : bus.in_lo[WIDTH-1];
  assign wdata    = {bus.in_op, zero_in, neg_in, hi_store, bus.in_lo};

  z_result_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr_n (clr_n),
    .push  (bus.in_valid),
    .pop   (bus.out_ready),
    .flush (flush),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (bus.count)
  );

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign {bus.z_op, bus.flag_zero, bus.flag_neg, bus.z_hi, bus.z_lo} = rdata;

endmodule

// File: tb/tb_z_result_stage.sv
// tb/tb_z_result_stage.sv - directed scoreboard bench for z_result_stage
// Inputs change and outputs are sampled around the falling edge.
module tb_z_result_stage;
  import z_result_stage_pkg::*;

  localparam int W = 32;
  localparam int D = 2;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         zero;
    logic         neg;
  } exp_t;

  logic clk = 1'b0;
  logic clr_n;
  logic flush;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  z_result_stage_if #(.WIDTH(W), .DEPTH(D), .OPW(5)) bus ();

  z_result_stage #(.WIDTH(W), .DEPTH(D), .OPW(5)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic [4:0] op, input logic [W-1:0] hi, input logic [W-1:0] lo);
    exp_t e;
    bit   w;
    w      = (op == OP_MUL) || (op == OP_DIV);
    e.op   = op;
    e.hi   = w ? hi : '0;
    e.lo   = lo;
    e.zero = w ? ({hi, lo} == 64'd0) : (lo == 32'd0);
    e.neg  = w ? hi[W-1] : lo[W-1];
    return e;
  endfunction

  task automatic chk_head();
    if (q.size() != 0) begin
      chk("z_op", 64'(bus.z_op), 64'(q[0].op));
      chk("z_hi", 64'(bus.z_hi), 64'(q[0].hi));
      chk("z_lo", 64'(bus.z_lo), 64'(q[0].lo));
      chk("flag_zero", 64'(bus.flag_zero), 64'(q[0].zero));
      chk("flag_neg", 64'(bus.flag_neg), 64'(q[0].neg));
    end else begin
      chk("empty_z", {27'd0, bus.z_op, bus.flag_zero, bus.flag_neg}, 64'd0);
      chk("empty_zhl", {bus.z_hi, bus.z_lo}, 64'd0);
    end
  endtask

  // one clock: entered and left just after a falling edge
  task automatic cyc(input bit v, input logic [4:0] op, input logic [W-1:0] hi,
                     input logic [W-1:0] lo, input bit rdy, input bit fl);
    bit do_push;
    bit do_pop;
    bus.in_valid  = v;
    bus.in_op     = v ? op : 5'bx;
    bus.in_hi     = v ? hi : 'x;
    bus.in_lo     = v ? lo : 'x;
    bus.out_ready = rdy;
    flush         = fl;
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(q.size() != D));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk_head();
    do_push = v && (q.size() != D) && !fl;
    do_pop  = rdy && (q.size() != 0) && !fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(make_exp(op, hi, lo));
    end
    @(negedge clk);
    chk("count", 64'(bus.count), 64'(q.size()));
  endtask

  task automatic reset_pulse();
    #2;
    clr_n = 1'b0;
    #1;
    q.delete();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk_head();
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    clr_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_hi     = '0;
    bus.in_lo     = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    reset_pulse();

    // idle with X on data inputs
    cyc(0, 5'd0, 32'd0, 32'd0, 1, 0);

    // SHR result, one-cycle latency, then drained
    cyc(1, OP_SHR, 32'd0, 32'h7FFF_FFF8, 0, 0);
    cyc(0, 5'd0, 32'd0, 32'd0, 1, 0);

    // backpressure: third beat refused until one cycle after first pop
    cyc(1, OP_SHL, 32'd0, 32'h0000_00A1, 0, 0);
    cyc(1, OP_ROR, 32'd0, 32'h0000_00B2, 0, 0);
    cyc(1, OP_ROL, 32'd0, 32'h0000_00C3, 0, 0);
    cyc(1, OP_ROL, 32'd0, 32'h0000_00C3, 1, 0);
    cyc(1, OP_ROL, 32'd0, 32'h0000_00C3, 1, 0);
    cyc(0, 5'd0, 32'd0, 32'd0, 1, 0);

    // simultaneous push and pop at count 1
    cyc(1, OP_ADD, 32'hDEAD_0000, 32'h0000_1111, 0, 0);
    cyc(1, OP_SUB, 32'd0, 32'h0000_2222, 1, 0);
    cyc(0, 5'd0, 32'd0, 32'd0, 1, 0);

    // width rule and flags
    cyc(1, OP_MUL, 32'h8000_0000, 32'd0, 0, 0);
    cyc(1, OP_SHL, 32'h0000_FFFF, 32'd0, 0, 0);
    cyc(0, 5'd0, 32'd0, 32'd0, 1, 0);
    cyc(1, OP_DIV, 32'd0, 32'd0, 1, 0);
    cyc(1, OP_SHRA, 32'h1234_5678, 32'hF000_0000, 1, 0);
    cyc(1, OP_DIV, 32'h0000_0001, 32'd0, 1, 0);
    cyc(0, 5'd0, 32'd0, 32'd0, 1, 0);
    cyc(0, 5'd0, 32'd0, 32'd0, 0, 0);

    // flush when full with a beat offered
    cyc(1, OP_AND, 32'd0, 32'h0000_0005, 0, 0);
    cyc(1, OP_OR, 32'd0, 32'h0000_0006, 0, 0);
    cyc(1, OP_ROR, 32'd0, 32'h0000_0007, 1, 1);
    cyc(0, 5'd0, 32'd0, 32'd0, 1, 0);

    // async reset while full
    cyc(1, OP_MUL, 32'h0000_0042, 32'h0000_0043, 0, 0);
    cyc(1, OP_SHR, 32'd0, 32'h8000_0001, 0, 0);
    reset_pulse();
    cyc(1, OP_SHL, 32'd0, 32'h0000_0099, 0, 0);
    cyc(0, 5'd0, 32'd0, 32'd0, 1, 0);
    cyc(0, 5'd0, 32'd0, 32'd0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
